// File: rtl/exhaustive_stim_checker.sv
// exhaustive_stim_checker
//
// Synthesizable sweep engine for a combinational DUT. On an accepted start
// it drives every N_IN-bit vector onto stim in ascending order and holds
// each one for SETTLE cycles. In a single CHECK cycle it then compares
// dut_out against the golden-model exp_out. It counts mismatching vectors
// and records the first one.
//
// Ports:
//   clk          sole clock, rising edge
//   rst          synchronous active-high reset
//   start        begin a sweep (accepted only in IDLE or DONE)
//   stop_on_fail latched at start; end the sweep at the first mismatch
//   stim         registered vector driven to the DUT inputs
//   dut_out      DUT outputs (sampled only in CHECK)
//   exp_out      golden-model outputs for the current stim
//   busy         high while settling or checking
//   done         sweep finished; sticky until the next start or rst
//   pass         done with zero mismatches
//   err_count    number of mismatching vectors (N_IN+1 bits, cannot overflow)
//   fail_vec     first mismatching vector
//   fail_valid   fail_vec holds a captured vector
module exhaustive_stim_checker #(
  parameter int N_IN   = 3,
  parameter int N_OUT  = 2,
  parameter int SETTLE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop_on_fail,
  output logic [N_IN-1:0]  stim,
  input  logic [N_OUT-1:0] dut_out,
  input  logic [N_OUT-1:0] exp_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [N_IN:0]    err_count,
  output logic [N_IN-1:0]  fail_vec,
  output logic             fail_valid
);

  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int ERR_W = N_IN + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] settle_cnt;
  logic             stop_latched;

  logic             mismatch;
  logic             last_vec;
  logic [ERR_W-1:0] err_next;

  // The compare result is meaningful only in CHECK. In every other state
  // it is ignored, so a DUT that is still settling cannot disturb it.
  always_comb begin
    mismatch = (dut_out != exp_out);
    last_vec = (stim == {N_IN{1'b1}});
    err_next = err_count + ERR_W'(mismatch);
  end

  // NOTE: every register is updated with non-blocking assignments, so each
  // right-hand side sees the pre-edge value. err_next therefore describes
  // this CHECK cycle only, and pass is derived from the same count that
  // err_count takes on.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      settle_cnt   <= '0;
      stop_latched <= 1'b0;
      stim         <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      err_count    <= '0;
      fail_vec     <= '0;
      fail_valid   <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state        <= S_SETTLE;
            settle_cnt   <= '0;
            stop_latched <= stop_on_fail;
            stim         <= '0;
            busy         <= 1'b1;
            done         <= 1'b0;
            pass         <= 1'b0;
            err_count    <= '0;
            fail_vec     <= '0;
            fail_valid   <= 1'b0;
          end
        end

        S_SETTLE: begin
          settle_cnt <= settle_cnt + CNT_W'(1);
          if (settle_cnt == CNT_LAST) state <= S_CHECK;
        end

        S_CHECK: begin
          if (mismatch) begin
            err_count <= err_next;
            if (!fail_valid) begin
              fail_vec   <= stim;
              fail_valid <= 1'b1;
            end
          end
          // stim is never advanced past the last vector, so it cannot
          // wrap. It also stays on the failing vector after an early stop.
          if ((mismatch && stop_latched) || last_vec) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == '0);
          end else begin
            state      <= S_SETTLE;
            settle_cnt <= '0;
            stim       <= stim + N_IN'(1);
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exhaustive_stim_checker.sv
module tb_exhaustive_stim_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       stop_on_fail;
  logic [2:0] stim;
  logic [1:0] dut_out;
  logic [1:0] exp_out;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] err_count;
  logic [2:0] fail_vec;
  logic       fail_valid;

  int errors = 0;
  int checks = 0;

  // Golden-model mode:
  //   0 = clean
  //   1 = fault at vector 5 (bit 0 flipped)
  //   2 = every vector wrong
  //   3 = fault at vector 2
  int mode = 0;

  always #5 clk = ~clk;

  // The combinational "DUT" under test is a small fixed function of stim.
  always_comb begin
    dut_out = {stim[2] ^ stim[0], stim[1] | stim[0]};
    exp_out = dut_out;
    case (mode)
      1:       if (stim == 3'd5) exp_out = dut_out ^ 2'b01;
      2:       exp_out = ~dut_out;
      3:       if (stim == 3'd2) exp_out = dut_out ^ 2'b10;
      default: exp_out = dut_out;
    endcase
  end

  exhaustive_stim_checker #(.N_IN(3), .N_OUT(2), .SETTLE(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop_on_fail(stop_on_fail),
    .stim        (stim),
    .dut_out     (dut_out),
    .exp_out     (exp_out),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .err_count   (err_count),
    .fail_vec    (fail_vec),
    .fail_valid  (fail_valid)
  );

  // Advance one cycle and sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // After this task returns, the time is 1 unit after the accepting edge (cycle 0).
  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Walk a sweep that ends after vector last_k.
  // Each vector is held for 5 cycles, and done rises at (last_k+1)*5.
  task automatic run_sweep(input int last_k, input string tag);
    int len = (last_k + 1) * 5;
    for (int t = 1; t <= len; t++) begin
      logic [2:0] e_stim;
      tick();
      e_stim = 3'((t / 5 > last_k) ? last_k : t / 5);
      checks++;
      if (stim !== e_stim || busy !== (t < len) || done !== (t == len)) begin
        errors++;
        $display("FAIL %s t=%0d: stim=%0d busy=%b done=%b, required stim=%0d busy=%b done=%b",
                 tag, t, stim, busy, done, e_stim, (t < len), (t == len));
      end
    end
  endtask

  task automatic check_result(input string tag, input logic e_pass, input logic [3:0] e_err,
                              input logic [2:0] e_vec, input logic e_valid);
    checks++;
    if (done !== 1'b1 || pass !== e_pass || err_count !== e_err ||
        fail_vec !== e_vec || fail_valid !== e_valid) begin
      errors++;
      $display("FAIL %s: done=%b pass=%b err=%0d vec=%0d valid=%b, required done=1 pass=%b err=%0d vec=%0d valid=%b",
               tag, done, pass, err_count, fail_vec, fail_valid, e_pass, e_err, e_vec, e_valid);
    end
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if (stim !== 3'd0 || busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 ||
        err_count !== 4'd0 || fail_vec !== 3'd0 || fail_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s: stim=%0d busy=%b done=%b pass=%b err=%0d vec=%0d valid=%b, required all 0",
               tag, stim, busy, done, pass, err_count, fail_vec, fail_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; stop_on_fail = 1'b0;
    tick(); tick();
    check_all_zero("reset_state");
    // rst has priority over start.
    start = 1'b1;
    tick();
    check_all_zero("reset_over_start");
    start = 1'b0; rst = 1'b0;
    tick();
    check_all_zero("idle_after_reset");
  endtask

  task automatic test_clean_sweep();
    mode = 0;
    pulse_start();
    run_sweep(7, "clean_sweep");
    check_result("clean_result", 1'b1, 4'd0, 3'd0, 1'b0);
    tick(); tick(); tick();
    checks++;
    if (done !== 1'b1 || stim !== 3'd7 || busy !== 1'b0) begin
      errors++;
      $display("FAIL done_sticky: done=%b stim=%0d busy=%b, required done=1 stim=7 busy=0",
               done, stim, busy);
    end
  endtask

  task automatic test_single_fault();
    mode = 1;
    pulse_start();
    run_sweep(7, "single_sweep");
    check_result("single_result", 1'b0, 4'd1, 3'd5, 1'b1);
  endtask

  task automatic test_restart_from_done();
    mode = 0;
    pulse_start();
    run_sweep(7, "restart_sweep");
    check_result("restart_result", 1'b1, 4'd0, 3'd0, 1'b0);
  endtask

  task automatic test_total_fault();
    mode = 2;
    pulse_start();
    run_sweep(7, "total_sweep");
    check_result("total_result", 1'b0, 4'b1000, 3'd0, 1'b1);
  endtask

  task automatic test_stop_on_fail();
    mode = 3;
    stop_on_fail = 1'b1;
    pulse_start();
    stop_on_fail = 1'b0;
    run_sweep(2, "stop_sweep");
    check_result("stop_result", 1'b0, 4'd1, 3'd2, 1'b1);
    tick(); tick();
    checks++;
    if (stim !== 3'd2 || busy !== 1'b0) begin
      errors++;
      $display("FAIL stop_hold: stim=%0d busy=%b, required stim=2 busy=0", stim, busy);
    end
  endtask

  task automatic test_reset_midrun_and_busy_start();
    mode = 0;
    pulse_start();
    // Advance to t=16, where stim is 3.
    for (int i = 0; i < 16; i++) tick();
    checks++;
    if (stim !== 3'd3 || busy !== 1'b1) begin
      errors++;
      $display("FAIL midrun_pos: stim=%0d busy=%b, required stim=3 busy=1", stim, busy);
    end
    pulse_start();  // t=17; this start must be ignored.
    checks++;
    if (stim !== 3'd3 || busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL busy_start_ignored: stim=%0d busy=%b done=%b, required stim=3 busy=1 done=0",
               stim, busy, done);
    end
    tick(); tick(); tick();  // t=20
    checks++;
    if (stim !== 3'd4) begin
      errors++;
      $display("FAIL busy_start_timeline: stim=%0d, required 4", stim);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_all_zero("midrun_reset");
    tick();
    check_all_zero("idle_after_midrun_reset");
    pulse_start();
    run_sweep(7, "post_reset_sweep");
    check_result("post_reset_result", 1'b1, 4'd0, 3'd0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_clean_sweep();
    test_single_fault();
    test_restart_from_done();
    test_total_fault();
    test_stop_on_fail();
    test_reset_midrun_and_busy_start();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
